cv32e40p_x_result_if: RTL

CV32E40P_X_RESULT_IF -- requirements
Module: cv32e40p_x_result_if

---
 rtl/cv32e40p_pkg.sv | 29 ++
 rtl/cv32e40p_x_result_fifo.sv | 85 ++++++++
 rtl/cv32e40p_x_result_if.sv | 139 +++++++++++++
 3 files changed

// File: rtl/cv32e40p_pkg.sv
// Shared types and constants for the coprocessor result interface.
// Optional feature macro used by cv32e40p_x_result_if: CV32E40P_X_RESULT_BYPASS_EN.
package cv32e40p_pkg;

  // Default number of result FIFO entries / outstanding offloads
  localparam int unsigned X_RESULT_DEPTH = 4;

  // Register file geometry
  localparam int unsigned X_RD_W   = 5;
  localparam int unsigned X_DATA_W = 32;
  localparam int unsigned NUM_GPR  = 32;

  // One coprocessor result: destination register plus data
  typedef struct packed {
    logic [X_RD_W-1:0]   rd;
    logic [X_DATA_W-1:0] data;
  } x_result_t;

  // Decode a register index into a one-hot GPR mask; x0 is never tracked
  function automatic logic [NUM_GPR-1:0] gpr_onehot(input logic [X_RD_W-1:0] rd);
    logic [NUM_GPR-1:0] mask;
    mask = '0;
    if (rd != '0) begin
      mask[rd] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/cv32e40p_x_result_fifo.sv
// Result FIFO for coprocessor writebacks. The head entry is visible
// combinationally so the core can consume it in the cycle it appears.
// Head outputs read as zero while the FIFO is empty.
module cv32e40p_x_result_fifo
  import cv32e40p_pkg::*;
#(
  parameter int unsigned DEPTH = X_RESULT_DEPTH
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  x_result_t push_data,
  input  logic      pop,
  output x_result_t head,
  output logic      full,
  output logic      empty
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  x_result_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   wr_ptr_next;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW-1:0]   rd_ptr_next;
  logic [AW:0]     count_reg;
  logic [AW:0]     count_next;
  logic            push_eff;
  logic            pop_eff;

  assign full  = (count_reg == DEPTH_CNT);
  assign empty = (count_reg == '0);

  // A push into a full FIFO or a pop from an empty one is ignored
  assign push_eff = push & ~full;
  assign pop_eff  = pop & ~empty;

  // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is a power of two)
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push_eff) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (pop_eff) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
    case ({push_eff, pop_eff})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage write; contents need no reset since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (push_eff) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Head of queue, forced to zero when nothing is stored
  always_comb begin
    head = '0;
    if (!empty) begin
      head = mem[rd_ptr_reg];
    end
  end

endmodule

// File: rtl/cv32e40p_x_result_if.sv
// Coprocessor result interface for the EX-stage write port.
// Tracks offloaded instructions in a per-GPR scoreboard and an outstanding
// counter, queues returned results in a FIFO and presents them in order.
// Optional feature: define CV32E40P_X_RESULT_BYPASS_EN to let a result that
// arrives while the FIFO is empty reach the write port in the same cycle.
module cv32e40p_x_result_if
  import cv32e40p_pkg::*;
#(
  parameter int unsigned DEPTH = X_RESULT_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid_i,
  input  logic [X_RD_W-1:0]   issue_rd_i,
  output logic                issue_ready_o,
  input  logic                res_valid_i,
  input  logic [X_RD_W-1:0]   res_rd_i,
  input  logic [X_DATA_W-1:0] res_data_i,
  output logic                res_ready_o,
  output logic                x_rvalid_o,
  output logic [X_RD_W-1:0]   x_rd_o,
  output logic [X_DATA_W-1:0] x_data_o,
  input  logic                x_rready_i,
  output logic [NUM_GPR-1:0]  x_rd_busy_o,
  output logic                x_err_o
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [NUM_GPR-1:0] busy_reg;
  logic [NUM_GPR-1:0] busy_next;
  logic [NUM_GPR-1:0] busy_set;
  logic [NUM_GPR-1:0] busy_clr;
  logic [AW:0]        outstanding_reg;
  logic [AW:0]        outstanding_next;
  logic               err_reg;
  logic               err_next;

  logic               issue_accept;
  logic               res_accept;
  logic               retire;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  x_result_t          fifo_head;
  x_result_t          res_in;
  x_result_t          wb_result;

  assign res_in = '{rd: res_rd_i, data: res_data_i};

  // Handshakes: issue stalls on a full window or a pending write to the same rd
  assign issue_ready_o = (outstanding_reg < DEPTH_CNT) & ~busy_reg[issue_rd_i];
  assign issue_accept  = issue_valid_i & issue_ready_o;
  assign res_ready_o   = ~fifo_full;
  assign res_accept    = res_valid_i & res_ready_o;
  assign retire        = x_rvalid_o & x_rready_i;

`ifdef CV32E40P_X_RESULT_BYPASS_EN
  // Write-port selection: an arriving result may pass straight through an empty FIFO
  always_comb begin
    x_rvalid_o = ~fifo_empty;
    wb_result  = fifo_head;
    fifo_push  = res_accept;
    fifo_pop   = retire & ~fifo_empty;
    if (fifo_empty && res_valid_i) begin
      x_rvalid_o = 1'b1;
      wb_result  = res_in;
      fifo_push  = res_accept & ~x_rready_i;
    end
  end
`else
  // Write-port selection: results always pass through the FIFO (one-cycle latency)
  always_comb begin
    x_rvalid_o = ~fifo_empty;
    wb_result  = fifo_head;
    fifo_push  = res_accept;
    fifo_pop   = retire;
  end
`endif

  assign x_rd_o   = wb_result.rd;
  assign x_data_o = wb_result.data;

  cv32e40p_x_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (res_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Per-GPR set/clear strobes; x0 is hard-wired clear
  assign busy_set[0] = 1'b0;
  assign busy_clr[0] = 1'b0;
  for (genvar gi = 1; gi < NUM_GPR; gi++) begin : g_busy
    assign busy_set[gi] = issue_accept & (issue_rd_i == X_RD_W'(gi));
    assign busy_clr[gi] = retire & (x_rd_o == X_RD_W'(gi));
  end

  // Scoreboard, outstanding counter and sticky error next-state
  always_comb begin
    busy_next        = (busy_reg & ~busy_clr) | busy_set;
    outstanding_next = outstanding_reg;
    err_next         = err_reg;
    if (issue_accept && !(retire && outstanding_reg != '0)) begin
      outstanding_next = outstanding_reg + 1'b1;
    end else if (!issue_accept && retire && outstanding_reg != '0) begin
      outstanding_next = outstanding_reg - 1'b1;
    end
    // A result for a register nobody is waiting on is a protocol error
    if (res_accept && (res_rd_i != '0) && !busy_reg[res_rd_i]) begin
      err_next = 1'b1;
    end
  end

  // Scoreboard, counter and error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg        <= '0;
      outstanding_reg <= '0;
      err_reg         <= 1'b0;
    end else begin
      busy_reg        <= busy_next;
      outstanding_reg <= outstanding_next;
      err_reg         <= err_next;
    end
  end

  assign x_rd_busy_o = busy_reg;
  assign x_err_o     = err_reg;

endmodule
